// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle control sequencer for an RV32I core. Spreads each
//                instruction over 3-5 states, time-sharing the instruction
//                memory, ALU, register file and data memory. Both memories
//                may stretch their states through a req/ready handshake.
//                Also keeps a retired-instruction counter and a sticky trap
//                flag raised by unsupported opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        oldpc_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ab_write,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        aluout_write,
    output logic        mdr_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halted
);

    // ------------------------------------------------------------------------
    // Supported opcodes (instr[6:0])
    // ------------------------------------------------------------------------
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU_Ctrl operation selects
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RFN   = 2'b10;
    localparam logic [1:0] ALU_IFN   = 2'b11;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_WB_MEM   = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_WB_ALU   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        halted_q;
    logic        halted_d;

    // Retire qualifier shared by next-state, counter and output logic
    logic        retire_w;

    // Instruction completes in this cycle: write-back states, the branch
    // state, or a store whose data access is acknowledged.
    always_comb begin
        retire_w = 1'b0;
        case (state_q)
            S_WB_MEM, S_WB_ALU, S_BRANCH: retire_w = 1'b1;
            S_MEM_WR:                     retire_w = dmem_ready;
            default:                      retire_w = 1'b0;
        endcase
    end

    // Next-state selection; run is only consulted in IDLE and at retirement
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_BRANCH: state_d = S_BRANCH;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                // Only loads and stores reach this state
                state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                if (dmem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                if (dmem_ready) begin
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC_R,
            S_EXEC_I: begin
                state_d = S_WB_ALU;
            end
            S_WB_MEM,
            S_WB_ALU,
            S_BRANCH: begin
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                // Only reset leaves the trap state
                state_d = S_TRAP;
            end
            default: begin
                // Unused encodings fall back to a safe idle
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter advances on every retirement and wraps naturally at 2^32;
    // the trap flag latches once the sequencer enters TRAP.
    always_comb begin
        instret_d = retire_w ? (instret_q + 32'd1) : instret_q;
        halted_d  = halted_q | (state_d == S_TRAP);
    end

    // State, counter and trap flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= 32'd0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            halted_q  <= halted_d;
        end
    end

    // Control decode from state plus per-state ready/zero qualifiers
    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        oldpc_write  = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        ab_write     = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Request held until the word arrives; PC advances by 4
                imem_req    = 1'b1;
                ir_write    = imem_ready;
                oldpc_write = imem_ready;
                pc_write    = imem_ready;
                pc_src      = 1'b0;
            end
            S_DECODE: begin
                // Read operands and precompute OldPC + imm as branch target
                ab_write     = 1'b1;
                alu_src_a    = 1'b1;
                alu_src_b    = 1'b1;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
            end
            S_MEM_ADDR: begin
                // Effective address A + imm
                alu_src_b    = 1'b1;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
            end
            S_MEM_RD: begin
                dmem_req  = 1'b1;
                dmem_we   = 1'b0;
                mdr_write = dmem_ready;
            end
            S_MEM_WR: begin
                // ALUOut holds the address throughout the wait
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC_R: begin
                alu_op       = ALU_RFN;
                aluout_write = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_b    = 1'b1;
                alu_op       = ALU_IFN;
                aluout_write = 1'b1;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                // BEQ: compare A - B, take ALUOut target when equal
                alu_op   = ALU_SUB;
                pc_src   = 1'b1;
                pc_write = zero;
            end
            default: begin
                // IDLE and TRAP drive no control
            end
        endcase
    end

    assign retire  = retire_w;
    assign instret = instret_q;
    assign halted  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Table-driven bench for multicycle_ctrl plus hand-written
//                sequences for counter wrap and reset during a memory wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       oldpc_write;
        logic       pc_write;
        logic       pc_src;
        logic       ab_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       aluout_write;
        logic       mdr_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic        rst;
        logic        run;
        logic [6:0]  opc;
        logic        zero;
        logic        ir;
        logic        dr;
        ctl_t        exp;
        logic [31:0] instret;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic        oldpc_write;
    logic        pc_write;
    logic        pc_src;
    logic        ab_write;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        aluout_write;
    logic        mdr_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        retire;
    logic [31:0] instret;
    logic        halted;

    ctl_t act;
    vec_t vq[$];
    int   n_vec;
    int   n_err;

    ctl_t e_idle, e_fwait, e_fgo, e_dec, e_madr, e_rwait, e_rgo, e_wwait;
    ctl_t e_wgo, e_wbm, e_exr, e_exi, e_wba, e_br1, e_br0, e_trap;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .opcode       (opcode),
        .zero         (zero),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_write     (ir_write),
        .oldpc_write  (oldpc_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ab_write     (ab_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .aluout_write (aluout_write),
        .mdr_write    (mdr_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .retire       (retire),
        .instret      (instret),
        .halted       (halted)
    );

    assign act = {imem_req, dmem_req, dmem_we, ir_write, oldpc_write, pc_write,
                  pc_src, ab_write, alu_src_a, alu_src_b, alu_op, aluout_write,
                  mdr_write, reg_write, mem_to_reg, retire, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic rn, input logic [6:0] op,
                       input logic z, input logic ir, input logic dr,
                       input ctl_t e, input logic [31:0] ins);
        vec_t v;
        v.rst = r;  v.run = rn; v.opc = op; v.zero = z;
        v.ir  = ir; v.dr  = dr; v.exp = e;  v.instret = ins;
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs (called at posedge+1), check mid-cycle,
    // then advance to just after the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        rst = v.rst; run = v.run; opcode = v.opc; zero = v.zero;
        imem_ready = v.ir; dmem_ready = v.dr;
        #3;
        n_vec++;
        if (act !== v.exp) begin
            n_err++;
            $display("FAIL %s ctl: got %h expected %h", tag, act, v.exp);
        end
        if (instret !== v.instret) begin
            n_err++;
            $display("FAIL %s instret: got %h expected %h", tag, instret, v.instret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic r, input logic rn,
                        input logic [6:0] op, input logic z, input logic ir,
                        input logic dr, input ctl_t e, input logic [31:0] ins);
        vec_t v;
        v.rst = r;  v.run = rn; v.opc = op; v.zero = z;
        v.ir  = ir; v.dr  = dr; v.exp = e;  v.instret = ins;
        apply(tag, v);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Expected control bundles per state/qualifier
        e_idle  = '0;
        e_fwait = '0; e_fwait.imem_req = 1'b1;
        e_fgo   = e_fwait; e_fgo.ir_write = 1'b1; e_fgo.oldpc_write = 1'b1; e_fgo.pc_write = 1'b1;
        e_dec   = '0; e_dec.ab_write = 1'b1; e_dec.alu_src_a = 1'b1; e_dec.alu_src_b = 1'b1;
        e_dec.aluout_write = 1'b1;
        e_madr  = '0; e_madr.alu_src_b = 1'b1; e_madr.aluout_write = 1'b1;
        e_rwait = '0; e_rwait.dmem_req = 1'b1;
        e_rgo   = e_rwait; e_rgo.mdr_write = 1'b1;
        e_wwait = '0; e_wwait.dmem_req = 1'b1; e_wwait.dmem_we = 1'b1;
        e_wgo   = e_wwait; e_wgo.retire = 1'b1;
        e_wbm   = '0; e_wbm.reg_write = 1'b1; e_wbm.mem_to_reg = 1'b1; e_wbm.retire = 1'b1;
        e_exr   = '0; e_exr.alu_op = 2'b10; e_exr.aluout_write = 1'b1;
        e_exi   = '0; e_exi.alu_src_b = 1'b1; e_exi.alu_op = 2'b11; e_exi.aluout_write = 1'b1;
        e_wba   = '0; e_wba.reg_write = 1'b1; e_wba.retire = 1'b1;
        e_br0   = '0; e_br0.alu_op = 2'b01; e_br0.pc_src = 1'b1; e_br0.retire = 1'b1;
        e_br1   = e_br0; e_br1.pc_write = 1'b1;
        e_trap  = '0; e_trap.halted = 1'b1;

        // rst run opcode zero imem_rdy dmem_rdy expected instret
        add(0, 0, OP_R,   0, 1, 1, e_idle,  0);  // reset state, stray readies ignored
        add(0, 1, OP_R,   0, 0, 0, e_idle,  0);  // run sampled
        add(0, 1, OP_R,   0, 1, 0, e_fgo,   0);
        add(0, 1, OP_R,   0, 0, 0, e_dec,   0);
        add(0, 1, OP_R,   0, 0, 1, e_exr,   0);
        add(0, 1, OP_R,   0, 0, 0, e_wba,   0);  // R retires in cycle 4
        add(0, 1, OP_LD,  0, 1, 0, e_fgo,   1);
        add(0, 1, OP_LD,  0, 0, 0, e_dec,   1);
        add(0, 1, OP_LD,  0, 0, 0, e_madr,  1);
        add(0, 1, OP_LD,  0, 0, 0, e_rwait, 1);
        add(0, 1, OP_LD,  0, 0, 0, e_rwait, 1);
        add(0, 1, OP_LD,  0, 0, 0, e_rwait, 1);
        add(0, 1, OP_LD,  0, 0, 1, e_rgo,   1);
        add(0, 1, OP_LD,  0, 0, 0, e_wbm,   1);  // LOAD retires in cycle 8
        add(0, 1, OP_BR,  1, 1, 0, e_fgo,   2);
        add(0, 1, OP_BR,  1, 0, 0, e_dec,   2);
        add(0, 1, OP_BR,  1, 0, 0, e_br1,   2);  // taken
        add(0, 1, OP_BR,  0, 1, 0, e_fgo,   3);
        add(0, 1, OP_BR,  0, 0, 0, e_dec,   3);
        add(0, 1, OP_BR,  0, 0, 0, e_br0,   3);  // not taken
        add(0, 1, OP_I,   0, 1, 0, e_fgo,   4);
        add(0, 1, OP_I,   0, 0, 0, e_dec,   4);
        add(0, 0, OP_I,   0, 0, 0, e_exi,   4);  // run dropped mid-instruction
        add(0, 0, OP_I,   0, 0, 0, e_wba,   4);
        add(0, 0, OP_I,   0, 1, 1, e_idle,  5);
        add(0, 1, OP_ST,  0, 0, 0, e_idle,  5);  // run reasserted
        add(0, 1, OP_ST,  0, 0, 0, e_fwait, 5);  // fetch wait state
        add(0, 1, OP_ST,  0, 1, 0, e_fgo,   5);
        add(0, 1, OP_ST,  0, 0, 0, e_dec,   5);
        add(0, 1, OP_ST,  0, 0, 0, e_madr,  5);
        add(0, 1, OP_ST,  0, 0, 0, e_wwait, 5);
        add(0, 1, OP_ST,  0, 0, 1, e_wgo,   5);
        add(0, 1, OP_BAD, 0, 1, 0, e_fgo,   6);
        add(0, 1, OP_BAD, 0, 0, 0, e_dec,   6);
        add(0, 1, OP_BAD, 0, 1, 1, e_trap,  6);
        add(0, 1, OP_R,   0, 1, 1, e_trap,  6);  // trap ignores run
        add(1, 1, OP_R,   0, 1, 1, e_trap,  6);  // reset edge at end of cycle
        add(0, 0, OP_R,   0, 0, 0, e_idle,  0);  // halted and instret cleared

        rst = 1'b1; run = 1'b0; opcode = OP_R; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vq[i]) begin
            apply($sformatf("vec%0d", i), vq[i]);
        end

        // Counter wrap: preload all-ones right before an R-type retires
        step("wrap_idle",  0, 1, OP_R, 0, 0, 0, e_idle, 0);
        step("wrap_fetch", 0, 1, OP_R, 0, 1, 0, e_fgo,  0);
        step("wrap_dec",   0, 1, OP_R, 0, 0, 0, e_dec,  0);
        step("wrap_exec",  0, 1, OP_R, 0, 0, 0, e_exr,  0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        n_vec++;
        if (instret !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_preload instret: got %h expected ffffffff", instret);
        end
        step("wrap_wb",    0, 0, OP_R, 0, 0, 0, e_wba,  32'hFFFF_FFFF);
        step("wrap_after", 0, 0, OP_R, 0, 0, 0, e_idle, 32'h0000_0000);

        // Reset while a store is waiting on the data memory
        step("rstw_idle",  0, 1, OP_ST, 0, 0, 0, e_idle,  0);
        step("rstw_fetch", 0, 1, OP_ST, 0, 1, 0, e_fgo,   0);
        step("rstw_dec",   0, 1, OP_ST, 0, 0, 0, e_dec,   0);
        step("rstw_addr",  0, 1, OP_ST, 0, 0, 0, e_madr,  0);
        step("rstw_wait",  0, 1, OP_ST, 0, 0, 0, e_wwait, 0);
        step("rstw_rst",   1, 1, OP_ST, 0, 0, 0, e_wwait, 0);
        step("rstw_post",  0, 0, OP_ST, 0, 1, 1, e_idle,  0);
        step("rstw_hold",  0, 0, OP_ST, 0, 0, 1, e_idle,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
